// File: rtl/uart_mirror_pkg.sv
// Shared widths and drain FSM encoding for the UART mirror transmit path.
package uart_mirror_pkg;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PRESENT = 2'd2
    } drain_state_e;

endpackage

// File: rtl/tx_drain_if.sv
// Bundle between tx_drain, the receive-side writer, the external byte RAM and the UART transmitter.
interface tx_drain_if #(
    parameter int ADDR_WIDTH = uart_mirror_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = uart_mirror_pkg::DEF_DATA_WIDTH
);
    logic                  WR_EN;
    logic                  RAM_WR_EN;
    logic [ADDR_WIDTH-1:0] RAM_WR_ADDR;
    logic [ADDR_WIDTH-1:0] RAM_RD_ADDR;
    logic [DATA_WIDTH-1:0] RAM_DOUT;
    logic [DATA_WIDTH-1:0] TX_DATA;
    logic                  TX_VALID;
    logic                  TX_READY;
    logic [ADDR_WIDTH:0]   COUNT;
    logic                  EMPTY;
    logic                  OVERFLOW;

    modport master (
        input  WR_EN, RAM_DOUT, TX_READY,
        output RAM_WR_EN, RAM_WR_ADDR, RAM_RD_ADDR, TX_DATA, TX_VALID,
               COUNT, EMPTY, OVERFLOW
    );

    modport slave (
        output WR_EN, RAM_DOUT, TX_READY,
        input  RAM_WR_EN, RAM_WR_ADDR, RAM_RD_ADDR, TX_DATA, TX_VALID,
               COUNT, EMPTY, OVERFLOW
    );
endinterface

// File: rtl/tx_drain.sv
// Ring-buffer pointer/count manager draining an external RAM into a UART transmitter.
// Write-to-valid latency 2 edges; one pop per 3 cycles at most; TX_DATA held until TX_READY.
module tx_drain
    import uart_mirror_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic       CLK,
    input  logic       RST,
    tx_drain_if.master bus
);

    localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    drain_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  overflow_q, overflow_d;

    logic full;
    logic wr_accept;
    logic pop;

    always_comb begin
        full      = (count_q == CNT_FULL);
        wr_accept = bus.WR_EN && !full;
        pop       = (state_q == ST_PRESENT) && bus.TX_READY;
    end

    // Count only distinguishes full from empty once the pointers have wrapped onto each other.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (bus.WR_EN && full) begin
            overflow_d = 1'b1;
        end
    end

    // WAIT exists to give the synchronous RAM one cycle to return the byte at rd_ptr.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;

        case (state_q)
            ST_IDLE: begin
                tx_valid_d = 1'b0;
                if (count_q != '0) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tx_data_d  = bus.RAM_DOUT;
                tx_valid_d = 1'b1;
                state_d    = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bus.TX_READY) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.RAM_WR_EN   = wr_accept;
    assign bus.RAM_WR_ADDR = wr_ptr_q;
    assign bus.RAM_RD_ADDR = rd_ptr_q;
    assign bus.COUNT       = count_q;
    assign bus.EMPTY       = (count_q == '0);
    assign bus.TX_DATA     = tx_data_q;
    assign bus.TX_VALID    = tx_valid_q;
    assign bus.OVERFLOW    = overflow_q;

endmodule

// File: tb/tb_tx_drain.sv
// Directed bench for tx_drain with a behavioural 512x8 synchronous-read RAM beside it.
`timescale 1ns/1ps
module tb_tx_drain;
    import uart_mirror_pkg::*;

    localparam int AW    = DEF_ADDR_WIDTH;
    localparam int DW    = DEF_DATA_WIDTH;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tx_drain_if bus ();

    tx_drain #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] wr_byte;

    always @(posedge clk) begin
        if (bus.RAM_WR_EN) mem[bus.RAM_WR_ADDR] <= wr_byte;
        bus.RAM_DOUT <= mem[bus.RAM_RD_ADDR];
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] rx_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.WR_EN = 1'b0;
        bus.TX_READY = 1'b0;
        wr_byte = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Drains with TX_READY high; each presented byte is seen in exactly one sample window.
    task automatic collect(input int n, input int budget);
        int cyc;
        cyc = 0;
        bus.TX_READY = 1'b1;
        while (rx_q.size() < n && cyc < budget) begin
            if (bus.TX_VALID) rx_q.push_back(bus.TX_DATA);
            tick();
            cyc++;
        end
        bus.TX_READY = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i + (i / 256) * 85) % 256);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.WR_EN = 1'b0;
        bus.TX_READY = 1'b0;
        wr_byte = '0;
        #2;
        n_cmp++; if (bus.COUNT !== 10'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", bus.COUNT); end
        n_cmp++; if (bus.EMPTY !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b expected 1", bus.EMPTY); end
        n_cmp++; if (bus.TX_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus.TX_VALID); end
        n_cmp++; if (bus.TX_DATA !== 8'h00) begin n_err++; $display("FAIL reset_data: got %0h expected 0", bus.TX_DATA); end
        n_cmp++; if (bus.OVERFLOW !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", bus.OVERFLOW); end
        n_cmp++; if (bus.RAM_WR_ADDR !== 9'd0 || bus.RAM_RD_ADDR !== 9'd0) begin
            n_err++; $display("FAIL reset_ptrs: got wr %0d rd %0d expected 0 0", bus.RAM_WR_ADDR, bus.RAM_RD_ADDR); end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_byte();
        do_reset();
        bus.TX_READY = 1'b1;
        bus.WR_EN = 1'b1;
        wr_byte = 8'h41;
        #1;
        n_cmp++; if (bus.RAM_WR_EN !== 1'b1) begin n_err++; $display("FAIL single_wren: got %b expected 1", bus.RAM_WR_EN); end
        tick();
        bus.WR_EN = 1'b0;
        n_cmp++; if (bus.COUNT !== 10'd1) begin n_err++; $display("FAIL single_count_k: got %0d expected 1", bus.COUNT); end
        n_cmp++; if (bus.TX_VALID !== 1'b0) begin n_err++; $display("FAIL single_valid_k: got %b expected 0", bus.TX_VALID); end
        tick();
        n_cmp++; if (bus.TX_VALID !== 1'b0) begin n_err++; $display("FAIL single_valid_k1: got %b expected 0", bus.TX_VALID); end
        tick();
        n_cmp++; if (bus.TX_VALID !== 1'b1) begin n_err++; $display("FAIL single_valid_k2: got %b expected 1", bus.TX_VALID); end
        n_cmp++; if (bus.TX_DATA !== 8'h41) begin n_err++; $display("FAIL single_data_k2: got %0h expected 41", bus.TX_DATA); end
        tick();
        n_cmp++; if (bus.TX_VALID !== 1'b0) begin n_err++; $display("FAIL single_valid_k3: got %b expected 0", bus.TX_VALID); end
        n_cmp++; if (bus.COUNT !== 10'd0 || bus.EMPTY !== 1'b1) begin
            n_err++; $display("FAIL single_count_k3: got %0d/%b expected 0/1", bus.COUNT, bus.EMPTY); end
        n_cmp++; if (bus.RAM_RD_ADDR !== 9'd1) begin n_err++; $display("FAIL single_rdaddr: got %0d expected 1", bus.RAM_RD_ADDR); end
        bus.TX_READY = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            bus.WR_EN = 1'b1;
            wr_byte = 8'((i + 1) * 16);
            tick();
        end
        bus.WR_EN = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.TX_VALID && bus.TX_DATA !== 8'h10) bad++;
            bus.TX_READY = 1'b0;
            tick();
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL b2b_stable: got %0d changed cycles expected 0", bad); end
        n_cmp++; if (bus.TX_VALID !== 1'b1 || bus.TX_DATA !== 8'h10) begin
            n_err++; $display("FAIL b2b_held: got valid %b data %0h expected 1 10", bus.TX_VALID, bus.TX_DATA); end
        n_cmp++; if (bus.COUNT !== 10'd3) begin n_err++; $display("FAIL b2b_count: got %0d expected 3", bus.COUNT); end
        rx_q.delete();
        collect(3, 30);
        n_cmp++; if (rx_q.size() != 3) begin n_err++; $display("FAIL b2b_n: got %0d expected 3", rx_q.size()); end
        else begin
            n_cmp++; if (rx_q[0] !== 8'h10 || rx_q[1] !== 8'h20 || rx_q[2] !== 8'h30) begin
                n_err++; $display("FAIL b2b_order: got %0h %0h %0h expected 10 20 30", rx_q[0], rx_q[1], rx_q[2]); end
        end
        n_cmp++; if (bus.COUNT !== 10'd0) begin n_err++; $display("FAIL b2b_final_count: got %0d expected 0", bus.COUNT); end
    endtask

    task automatic test_overflow();
        int bad, ffs;
        do_reset();
        bad = 0;
        ffs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.WR_EN = 1'b1;
            wr_byte = 8'(i % 255);
            tick();
        end
        n_cmp++; if (bus.COUNT !== 10'd512) begin n_err++; $display("FAIL ovf_full_count: got %0d expected 512", bus.COUNT); end
        wr_byte = 8'hFF;
        #1;
        n_cmp++; if (bus.RAM_WR_EN !== 1'b0) begin n_err++; $display("FAIL ovf_wren: got %b expected 0", bus.RAM_WR_EN); end
        tick();
        bus.WR_EN = 1'b0;
        n_cmp++; if (bus.OVERFLOW !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", bus.OVERFLOW); end
        n_cmp++; if (bus.COUNT !== 10'd512) begin n_err++; $display("FAIL ovf_count: got %0d expected 512", bus.COUNT); end
        n_cmp++; if (bus.RAM_WR_ADDR !== 9'd0 || bus.RAM_RD_ADDR !== 9'd0) begin
            n_err++; $display("FAIL ovf_ptrs: got wr %0d rd %0d expected 0 0", bus.RAM_WR_ADDR, bus.RAM_RD_ADDR); end
        rx_q.delete();
        collect(DEPTH, DEPTH * 3 + 20);
        for (int i = 0; i < rx_q.size(); i++) begin
            if (rx_q[i] !== 8'(i % 255)) bad++;
            if (rx_q[i] === 8'hFF) ffs++;
        end
        n_cmp++; if (rx_q.size() != DEPTH) begin n_err++; $display("FAIL ovf_drain_n: got %0d expected 512", rx_q.size()); end
        n_cmp++; if (bad != 0 || ffs != 0) begin n_err++; $display("FAIL ovf_drain_data: got %0d wrong %0d ff expected 0 0", bad, ffs); end
        bus.TX_READY = 1'b1;
        repeat (5) tick();
        bus.TX_READY = 1'b0;
        n_cmp++; if (bus.TX_VALID !== 1'b0 || bus.EMPTY !== 1'b1) begin
            n_err++; $display("FAIL ovf_after_drain: got valid %b empty %b expected 0 1", bus.TX_VALID, bus.EMPTY); end
        n_cmp++; if (bus.OVERFLOW !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", bus.OVERFLOW); end
    endtask

    // Runs straight after the overflow scenario so OVERFLOW is set going in.
    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            bus.WR_EN = 1'b1;
            wr_byte = 8'(8'hC0 + i);
            tick();
        end
        bus.WR_EN = 1'b0;
        n_cmp++; if (bus.TX_VALID !== 1'b1 || bus.COUNT !== 10'd4) begin
            n_err++; $display("FAIL rstmid_pre: got valid %b count %0d expected 1 4", bus.TX_VALID, bus.COUNT); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.TX_VALID !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", bus.TX_VALID); end
        n_cmp++; if (bus.COUNT !== 10'd0 || bus.EMPTY !== 1'b1) begin
            n_err++; $display("FAIL rstmid_count: got %0d/%b expected 0/1", bus.COUNT, bus.EMPTY); end
        n_cmp++; if (bus.OVERFLOW !== 1'b0) begin n_err++; $display("FAIL rstmid_ovf: got %b expected 0", bus.OVERFLOW); end
        n_cmp++; if (bus.TX_DATA !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %0h expected 0", bus.TX_DATA); end
        tick();
        rst = 1'b0;
        bus.TX_READY = 1'b1;
        repeat (6) tick();
        n_cmp++; if (bus.TX_VALID !== 1'b0 || bus.COUNT !== 10'd0) begin
            n_err++; $display("FAIL rstmid_discard: got valid %b count %0d expected 0 0", bus.TX_VALID, bus.COUNT); end
        bus.TX_READY = 1'b0;
    endtask

    task automatic test_simultaneous();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            bus.WR_EN = 1'b1;
            wr_byte = 8'(8'hA0 + i);
            tick();
        end
        bus.WR_EN = 1'b0;
        n_cmp++; if (bus.COUNT !== 10'd5 || bus.TX_VALID !== 1'b1 || bus.TX_DATA !== 8'hA0) begin
            n_err++; $display("FAIL simul_pre: got count %0d valid %b data %0h expected 5 1 a0", bus.COUNT, bus.TX_VALID, bus.TX_DATA); end
        bus.WR_EN = 1'b1;
        wr_byte = 8'hA5;
        bus.TX_READY = 1'b1;
        tick();
        bus.WR_EN = 1'b0;
        bus.TX_READY = 1'b0;
        n_cmp++; if (bus.COUNT !== 10'd5) begin n_err++; $display("FAIL simul_count: got %0d expected 5", bus.COUNT); end
        n_cmp++; if (bus.RAM_WR_ADDR !== 9'd6 || bus.RAM_RD_ADDR !== 9'd1) begin
            n_err++; $display("FAIL simul_ptrs: got wr %0d rd %0d expected 6 1", bus.RAM_WR_ADDR, bus.RAM_RD_ADDR); end
        rx_q.delete();
        collect(5, 40);
        for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 8'(8'hA1 + i)) bad++;
        n_cmp++; if (rx_q.size() != 5 || bad != 0) begin
            n_err++; $display("FAIL simul_drain: got %0d bytes %0d wrong expected 5 0", rx_q.size(), bad); end
    endtask

    task automatic test_wrap();
        int sent, cyc, bad;
        logic [AW-1:0] addr512;
        do_reset();
        sent = 0;
        cyc = 0;
        bad = 0;
        addr512 = '1;
        rx_q.delete();
        bus.TX_READY = 1'b1;
        while (rx_q.size() < 600 && cyc < 3000) begin
            if (bus.TX_VALID) begin
                if (rx_q.size() == 512) addr512 = bus.RAM_RD_ADDR;
                rx_q.push_back(bus.TX_DATA);
            end
            if (sent < 600) begin
                bus.WR_EN = 1'b1;
                wr_byte = pat(sent);
                sent++;
            end else begin
                bus.WR_EN = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.WR_EN = 1'b0;
        bus.TX_READY = 1'b0;
        for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== pat(i)) bad++;
        n_cmp++; if (rx_q.size() != 600) begin n_err++; $display("FAIL wrap_n: got %0d expected 600", rx_q.size()); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL wrap_data: got %0d wrong expected 0", bad); end
        n_cmp++; if (addr512 !== 9'd0) begin n_err++; $display("FAIL wrap_addr512: got %0d expected 0", addr512); end
        n_cmp++; if (bus.RAM_WR_ADDR !== 9'd88 || bus.RAM_RD_ADDR !== 9'd88) begin
            n_err++; $display("FAIL wrap_ptrs: got wr %0d rd %0d expected 88 88", bus.RAM_WR_ADDR, bus.RAM_RD_ADDR); end
        n_cmp++; if (bus.COUNT !== 10'd0 || bus.OVERFLOW !== 1'b0) begin
            n_err++; $display("FAIL wrap_final: got count %0d ovf %b expected 0 0", bus.COUNT, bus.OVERFLOW); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_simultaneous();
        test_wrap();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
